mmio_timer_led: RTL and testbench

- Memory-mapped responder on the ARM core's data port. It sits alongside dmem and answers the core's load/store traffic (we, a, wd → rd).
- Provides an LED output register and a prescaled down-counting timer with a sticky done flag.
- The top-level muxes ReadData between dmem and this block using `hit`.
- Reads are combinational, matching dmem timing for the single-cycle core. Writes take effect on the rising clk edge.

---
 rtl/mmio_timer_pkg.sv | 27 ++
 rtl/mmio_timer_led_prescaler.sv | 35 +++
 rtl/mmio_timer_led.sv | 161 ++++++++++++++++
 tb/tb_mmio_timer_led.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared register map, bit positions and state type for the MMIO timer/LED block.
// CTRL bit 3 (IRQ mask) only has storage when MMIO_TIMER_IRQ_EN is defined.
package mmio_timer_pkg;

    localparam logic [4:0] OFF_LED      = 5'h00;
    localparam logic [4:0] OFF_CTRL     = 5'h04;
    localparam logic [4:0] OFF_LOAD     = 5'h08;
    localparam logic [4:0] OFF_COUNT    = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;
    localparam logic [4:0] OFF_PRESCALE = 5'h14;

    localparam int CTRL_START    = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_STOP     = 2;
    localparam int CTRL_IRQ_MASK = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic {IDLE, RUN} timer_state_t;

    // Word-aligned byte offset inside the window; the byte lane bits are dropped.
    function automatic logic [4:0] reg_offset(input logic [2:0] word_sel);
        return {word_sel, 2'b00};
    endfunction

endpackage

// File: rtl/mmio_timer_led_prescaler.sv
// Prescaler for the MMIO timer: counts 0..prescale and pulses tick on the terminal value.
module mmio_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_reg;
    logic [PRESCALE_W-1:0] pcnt_next;

    assign tick = en && (pcnt_reg == prescale);

    always_comb begin
        pcnt_next = pcnt_reg;
        if (clear) begin
            pcnt_next = '0;
        end else if (en) begin
            pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
        end
    end

endmodule

// File: rtl/mmio_timer_led.sv
// Memory-mapped LED register plus prescaled down-counting timer with sticky DONE.
// Optional MMIO_TIMER_IRQ_EN adds CTRL bit 3 (IRQ mask) and the level irq output.
module mmio_timer_led
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic [7:0]  led
`ifdef MMIO_TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    timer_state_t          state_reg, state_next;
    logic [7:0]            led_reg;
    logic [31:0]           load_reg;
    logic [31:0]           count_reg, count_next;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic                  periodic_reg;
    logic                  done_reg, done_next;
    logic                  irq_mask_reg;

    logic [4:0]  sel;
    logic        wr, start_w, stop_w, clr_done_w;
    logic        set_done, tick, pre_clear, pre_en;
    logic [31:0] prescale_rd;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^a[1:0];

    assign hit        = (a[31:5] == BASE_ADDR[31:5]);
    assign sel        = reg_offset(a[4:2]);
    assign wr         = we && hit;
    assign start_w    = wr && (sel == OFF_CTRL) && wd[CTRL_START];
    assign stop_w     = wr && (sel == OFF_CTRL) && wd[CTRL_STOP];
    assign clr_done_w = wr && (sel == OFF_STATUS) && wd[STAT_DONE];

    // Prescaler restarts on any START and idles outside RUN.
    assign pre_clear = (state_reg == IDLE) || start_w;
    assign pre_en    = (state_reg == RUN);

    mmio_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (pre_clear),
        .en       (pre_en),
        .prescale (prescale_reg),
        .tick     (tick)
    );

    // STOP beats START; START always reloads COUNT from LOAD, a zero LOAD expires at once.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        set_done   = 1'b0;
        if (stop_w) begin
            state_next = IDLE;
        end else if (start_w) begin
            count_next = load_reg;
            if (load_reg != 32'd0) begin
                state_next = RUN;
            end else begin
                state_next = IDLE;
                set_done   = 1'b1;
            end
        end else if ((state_reg == RUN) && tick) begin
            if (count_reg <= 32'd1) begin
                set_done = 1'b1;
                if (periodic_reg) begin
                    count_next = load_reg;
                    state_next = (load_reg != 32'd0) ? RUN : IDLE;
                end else begin
                    count_next = 32'd0;
                    state_next = IDLE;
                end
            end else begin
                count_next = count_reg - 32'd1;
            end
        end
        done_next = (done_reg && !clr_done_w) || set_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            done_reg     <= 1'b0;
            led_reg      <= '0;
            load_reg     <= '0;
            prescale_reg <= '0;
            periodic_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            done_reg  <= done_next;
            if (wr) begin
                case (sel)
                    OFF_LED:      led_reg      <= wd[7:0];
                    OFF_CTRL:     periodic_reg <= wd[CTRL_PERIODIC];
                    OFF_LOAD:     load_reg     <= wd;
                    OFF_PRESCALE: prescale_reg <= wd[PRESCALE_W-1:0];
                    default:      ;
                endcase
            end
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask_reg <= 1'b0;
        end else if (wr && (sel == OFF_CTRL)) begin
            irq_mask_reg <= wd[CTRL_IRQ_MASK];
        end
    end

    assign irq = done_reg && irq_mask_reg;
`else
    assign irq_mask_reg = 1'b0;
`endif

    always_comb begin
        prescale_rd                   = '0;
        prescale_rd[PRESCALE_W-1:0]   = prescale_reg;
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (sel)
                OFF_LED:      rd[7:0] = led_reg;
                OFF_CTRL: begin
                    rd[CTRL_PERIODIC] = periodic_reg;
                    rd[CTRL_IRQ_MASK] = irq_mask_reg;
                end
                OFF_LOAD:     rd = load_reg;
                OFF_COUNT:    rd = count_reg;
                OFF_STATUS: begin
                    rd[STAT_BUSY] = (state_reg == RUN);
                    rd[STAT_DONE] = done_reg;
                end
                OFF_PRESCALE: rd = prescale_rd;
                default:      rd = '0;
            endcase
        end
    end

    assign led = led_reg;

endmodule

// File: tb/tb_mmio_timer_led.sv
// Self-checking bench for mmio_timer_led: directed scenarios then random traffic vs a reference model.
module tb_mmio_timer_led;

    localparam logic [31:0] BASE = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd;
    logic        hit;
    logic [7:0]  led;
`ifdef MMIO_TIMER_IRQ_EN
    logic        irq;
`endif

    mmio_timer_led #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .hit   (hit),
        .led   (led)
`ifdef MMIO_TIMER_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // Reference model: timer expressed as "edges until next tick" plus a remaining-tick count.
    logic [7:0]  m_led;
    logic [31:0] m_load, m_count;
    logic [15:0] m_prescale;
    logic        m_periodic, m_mask, m_done, m_busy;
    int          m_wait;

    task automatic model_reset();
        m_led = 0; m_load = 0; m_count = 0; m_prescale = 0;
        m_periodic = 0; m_mask = 0; m_done = 0; m_busy = 0; m_wait = 0;
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0:  return {24'h0, m_led};
            4:  return {28'h0, m_mask, 1'b0, m_periodic, 1'b0};
            8:  return m_load;
            12: return m_count;
            16: return {30'h0, m_done, m_busy};
            20: return {16'h0, m_prescale};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic w, input logic [31:0] addr, input logic [31:0] data);
        logic in_win, start, stop, clr, setd;
        int   off;
        in_win = w && (addr[31:5] == BASE[31:5]);
        off    = int'(addr[4:0]) & 28;
        start  = in_win && off == 4 && data[0];
        stop   = in_win && off == 4 && data[2];
        clr    = in_win && off == 16 && data[1];
        setd   = 0;
        if (stop) begin
            m_busy = 0;
        end else if (start) begin
            m_count = m_load;
            if (m_load != 0) begin
                m_busy = 1;
                m_wait = int'(m_prescale) + 1;
            end else begin
                m_busy = 0;
                setd   = 1;
            end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
                m_wait = int'(m_prescale) + 1;
                if (m_count == 1) begin
                    setd = 1;
                    if (m_periodic) begin
                        m_count = m_load;
                        if (m_load == 0) m_busy = 0;
                    end else begin
                        m_count = 0;
                        m_busy  = 0;
                    end
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
        m_done = (m_done && !clr) || setd;
        if (in_win) begin
            case (off)
                0:  m_led = data[7:0];
                4: begin
                    m_periodic = data[1];
`ifdef MMIO_TIMER_IRQ_EN
                    m_mask = data[3];
`endif
                end
                8:  m_load = data;
                20: m_prescale = data[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic check_reg(input int off);
        a = BASE + 32'(off);
        #1;
        chk($sformatf("hit@%02h", off), {31'h0, hit}, 32'h1);
        chk($sformatf("rd@%02h", off), rd, model_read(off));
    endtask

    task automatic check_outputs();
        chk("led", {24'h0, led}, {24'h0, m_led});
`ifdef MMIO_TIMER_IRQ_EN
        chk("irq", {31'h0, irq}, {31'h0, m_done & m_mask});
`endif
    endtask

    task automatic check_all();
        for (int off = 0; off < 32; off += 4) check_reg(off);
        check_outputs();
    endtask

    // One bus cycle: drive, clock, update model, then check at the falling edge.
    task automatic cycle(input logic w, input logic [31:0] addr, input logic [31:0] data);
        we = w; a = addr; wd = data;
        @(posedge clk);
        model_edge(w, addr, data);
        @(negedge clk);
        we = 0;
        check_outputs();
        check_reg(12);
        check_reg(16);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, BASE, 32'h0);
    endtask

    task automatic rd_word(input int off, output logic [31:0] v);
        a = BASE + 32'(off);
        #1;
        v = rd;
    endtask

    logic [31:0] v;

    initial begin
        model_reset();
        // Reset phase
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;
        @(negedge clk);
        check_all();
        a = 32'h0000_0820; #1;
        chk("hit_out_hi", {31'h0, hit}, 32'h0);
        chk("rd_out_hi", rd, 32'h0);
        a = 32'h1000_0800; #1;
        chk("hit_out_far", {31'h0, hit}, 32'h0);
        chk("rd_out_far", rd, 32'h0);

        // LED and unmapped offset
        cycle(1, BASE + 32'h00, 32'h0000_00A5);
        chk("led_a5", {24'h0, led}, 32'hA5);
        rd_word(0, v);
        chk("rd_led_a5", v, 32'h0000_00A5);
        cycle(1, BASE + 32'h1C, 32'hFFFF_FFFF);
        check_all();

        // One-shot: PRESCALE=2, LOAD=3 -> DONE 9 edges after START
        cycle(1, BASE + 32'h14, 32'd2);
        cycle(1, BASE + 32'h08, 32'd3);
        cycle(1, BASE + 32'h04, 32'h1);
        rd_word(16, v);
        chk("busy_after_start", v, 32'h1);
        idle(8);
        rd_word(16, v);
        chk("not_done_edge8", v, 32'h1);
        rd_word(12, v);
        chk("count_edge8", v, 32'h1);
        idle(1);
        rd_word(16, v);
        chk("done_edge9", v, 32'h2);
        rd_word(12, v);
        chk("count_zero", v, 32'h0);
        cycle(1, BASE + 32'h10, 32'h2);

        // Periodic with PRESCALE=0, LOAD=2
        cycle(1, BASE + 32'h14, 32'd0);
        cycle(1, BASE + 32'h08, 32'd2);
        cycle(1, BASE + 32'h04, 32'h3);
        idle(2);
        rd_word(16, v);
        chk("periodic_done1", v, 32'h3);
        cycle(1, BASE + 32'h10, 32'h2);
        rd_word(16, v);
        chk("periodic_cleared", v, 32'h1);
        idle(1);
        rd_word(16, v);
        chk("periodic_done2", v, 32'h3);
        cycle(1, BASE + 32'h04, 32'h6);
        rd_word(16, v);
        chk("stopped", v, 32'h2);
        cycle(1, BASE + 32'h10, 32'h2);

        // LOAD=0 START, then START|STOP
        cycle(1, BASE + 32'h04, 32'h0);
        cycle(1, BASE + 32'h08, 32'd0);
        cycle(1, BASE + 32'h04, 32'h1);
        rd_word(16, v);
        chk("load0_done", v, 32'h2);
        cycle(1, BASE + 32'h10, 32'h2);
        cycle(1, BASE + 32'h08, 32'd5);
        cycle(1, BASE + 32'h04, 32'h5);
        rd_word(16, v);
        chk("start_stop_idle", v, 32'h0);

`ifdef MMIO_TIMER_IRQ_EN
        cycle(1, BASE + 32'h08, 32'd0);
        cycle(1, BASE + 32'h04, 32'h9);
        chk("irq_set", {31'h0, irq}, 32'h1);
        cycle(1, BASE + 32'h10, 32'h2);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        cycle(1, BASE + 32'h08, 32'd5);
`endif

        // Reset asserted mid-count
        cycle(1, BASE + 32'h04, 32'h1);
        idle(2);
        #2 reset = 1'b0;
        model_reset();
        #1;
        rd_word(12, v);
        chk("rst_count", v, 32'h0);
        rd_word(16, v);
        chk("rst_status", v, 32'h0);
        #1 reset = 1'b1;
        @(negedge clk);
        check_all();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int          r;
            logic        w;
            logic [31:0] ad, d;
            r  = $urandom_range(0, 11);
            w  = 1;
            ad = BASE | 32'($urandom_range(0, 3));
            d  = $urandom;
            case (r)
                0, 1, 2: w = 0;
                3: ad = ad ^ (32'h20 << $urandom_range(0, 26));
                4: ad = ad | 32'h00;
                5, 6: begin ad = ad | 32'h04; d = 32'($urandom_range(0, 15)); end
                7: begin ad = ad | 32'h08; d = 32'($urandom_range(0, 4)); end
                8: ad = ad | 32'h10;
                9: if (!m_busy) begin ad = ad | 32'h14; d = 32'($urandom_range(0, 3)); end
                   else ad = ad | 32'h0C;
                default: ad = ad | (32'h18 + 32'(4 * $urandom_range(0, 1)));
            endcase
            cycle(w, ad, d);
            check_reg(4 * $urandom_range(0, 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
